// File: rtl/uart_word_xcvr_if.sv
// Command / serial / receive-word bundle shared by the UART transceiver and
// whatever drives it. The slave modport is the transceiver's view.
interface uart_word_xcvr_if #(
    parameter int DATA_W = 8,
    parameter int WORDS  = 2
);
    logic [DATA_W*WORDS-1:0] cmd_in;
    logic                    cmd_vld;
    logic                    cmd_rdy;
    logic                    tx;
    logic                    rx;
    logic                    read_vld;
    logic [DATA_W-1:0]       read_data;
    logic                    read_perr;
    logic                    read_ferr;

    modport master (
        output cmd_in, cmd_vld, rx,
        input  cmd_rdy, tx, read_vld, read_data, read_perr, read_ferr
    );

    modport slave (
        input  cmd_in, cmd_vld, rx,
        output cmd_rdy, tx, read_vld, read_data, read_perr, read_ferr
    );
endinterface

// File: rtl/uart_word_xcvr.sv
// Full-duplex UART transceiver.
// TX serialises a WORDS x DATA_W command as back-to-back frames, most
// significant word first. RX deserialises frames with mid-bit sampling and
// delivers one word at a time with parity and framing error flags.
module uart_word_xcvr #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int WORDS        = 2,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_word_xcvr_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam int WRD_W = $clog2(WORDS) + 1;
    localparam int CMD_W = DATA_W * WORDS;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // Parity bit for a word: odd parity makes the total count of ones odd.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_t              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]    tx_baud_q,  tx_baud_d;
    logic [BIT_W-1:0]    tx_bit_q,   tx_bit_d;
    logic [WRD_W-1:0]    tx_left_q,  tx_left_d;
    logic [DATA_W-1:0]   tx_sh_q,    tx_sh_d;
    logic                tx_par_q,   tx_par_d;
    logic [CMD_W-1:0]    cmd_q,      cmd_d;
    logic                tx_q,       tx_d;
    logic                rdy_q,      rdy_d;
    logic                tx_baud_end;

    assign tx_baud_end = (tx_baud_q == BAUD_LAST);

    // TX next state: walks each frame bit, then chains straight into the next word.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = (tx_state_q == S_IDLE) ? '0 : tx_baud_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_left_d  = tx_left_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        rdy_d      = rdy_q;

        case (tx_state_q)
            S_IDLE: begin
                if (bus.cmd_vld && rdy_q) begin
                    // Top word goes out first; remaining words shift up behind it.
                    tx_state_d = S_START;
                    tx_baud_d  = '0;
                    tx_d       = 1'b0;
                    rdy_d      = 1'b0;
                    tx_sh_d    = bus.cmd_in[CMD_W-1 -: DATA_W];
                    tx_par_d   = parity_bit(bus.cmd_in[CMD_W-1 -: DATA_W]);
                    cmd_d      = bus.cmd_in << DATA_W;
                    tx_left_d  = WRD_W'(WORDS - 1);
                end
            end
            S_START: begin
                if (tx_baud_end) begin
                    tx_state_d = S_DATA;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                end
            end
            S_DATA: begin
                if (tx_baud_end) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == DATA_LAST) begin
                        if (PARITY != 0) begin
                            tx_state_d = S_PAR;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            tx_bit_d   = '0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_d     = tx_sh_q[1];
                    end
                end
            end
            S_PAR: begin
                if (tx_baud_end) begin
                    tx_state_d = S_STOP;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_baud_end) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == STOP_LAST) begin
                        if (tx_left_q != '0) begin
                            // No idle gap: next start bit follows the last stop bit directly.
                            tx_state_d = S_START;
                            tx_d       = 1'b0;
                            tx_sh_d    = cmd_q[CMD_W-1 -: DATA_W];
                            tx_par_d   = parity_bit(cmd_q[CMD_W-1 -: DATA_W]);
                            cmd_d      = cmd_q << DATA_W;
                            tx_left_d  = tx_left_q - 1'b1;
                        end else begin
                            tx_state_d = S_IDLE;
                            tx_d       = 1'b1;
                            rdy_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_d       = 1'b1;
                rdy_d      = 1'b1;
            end
        endcase
    end

    // TX registers; tx itself is a flop so the pin never glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_left_q  <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            cmd_q      <= '0;
            tx_q       <= 1'b1;
            rdy_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_left_q  <= tx_left_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            rdy_q      <= rdy_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic                rx_meta_q;
    logic                rx_s_q;
    state_t              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]    rx_baud_q,  rx_baud_d;
    logic [BIT_W-1:0]    rx_bit_q,   rx_bit_d;
    logic [DATA_W-1:0]   rx_sh_q,    rx_sh_d;
    logic                rx_par_q,   rx_par_d;
    logic                rx_brk_q,   rx_brk_d;
    logic                vld_q,      vld_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic                perr_q,     perr_d;
    logic                ferr_q,     ferr_d;
    logic                rx_baud_end;

    assign rx_baud_end = (rx_baud_q == BAUD_LAST);

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // RX next state: start-edge detect, mid-bit sampling, word delivery.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = (rx_state_q == S_IDLE) ? '0 : rx_baud_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_brk_d   = rx_brk_q;
        vld_d      = 1'b0;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        case (rx_state_q)
            S_IDLE: begin
                // After a framing error the line must return high before re-arming.
                if (rx_brk_q) begin
                    if (rx_s_q) begin
                        rx_brk_d = 1'b0;
                    end
                end else if (!rx_s_q) begin
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d = '0;
                    if (rx_s_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_baud_end) begin
                    rx_baud_d = '0;
                    rx_sh_d   = {rx_s_q, rx_sh_q[DATA_W-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (rx_baud_end) begin
                    rx_baud_d  = '0;
                    rx_par_d   = rx_s_q;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_baud_end) begin
                    // Only the first stop bit is checked; go idle to catch the next edge.
                    rx_baud_d  = '0;
                    rx_state_d = S_IDLE;
                    vld_d      = 1'b1;
                    data_d     = rx_sh_q;
                    perr_d     = (PARITY != 0) && (rx_par_q != parity_bit(rx_sh_q));
                    ferr_d     = ~rx_s_q;
                    rx_brk_d   = ~rx_s_q;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
            end
        endcase
    end

    // RX registers, including the delivered word and its flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= S_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_brk_q   <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_brk_q   <= rx_brk_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.cmd_rdy   = rdy_q;
    assign bus.tx        = tx_q;
    assign bus.read_vld  = vld_q;
    assign bus.read_data = data_q;
    assign bus.read_perr = perr_q;
    assign bus.read_ferr = ferr_q;

endmodule
